// File: rtl/calc_uart_responder_if.sv
// Byte-level interface between the calculator frame responder and a uart core / system.
// slave is the responder side, master is the uart core plus system side that drives it.
interface calc_uart_responder_if;
  logic       e;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] result;
  logic       div0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport slave (
    input  e, rx_data, rx_valid, tx_busy,
    output tx_data, tx_start, result, div0, frame_err, overrun, busy
  );

  modport master (
    output e, rx_data, rx_valid, tx_busy,
    input  tx_data, tx_start, result, div0, frame_err, overrun, busy
  );
endinterface

// File: rtl/calc_uart_responder.sv
// Calculator frame responder: parses A, operator, B from uart bytes, computes an 8-bit
// result (iterative restoring divider for '/') and hands the result byte back to the uart core.
module calc_uart_responder #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  ERR_BYTE    = 8'hFF
) (
  input logic                  clk,
  input logic                  rst,
  calc_uart_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, GOT_A, GOT_OP, CALC, SEND, WAIT_TX} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_SUB = 8'h2D;
  localparam logic [7:0] CH_MUL = 8'h78;
  localparam logic [7:0] CH_DIV = 8'h2F;

  localparam int            TW      = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  op_t           op;
  logic [7:0]    opnd_a;
  logic [7:0]    opnd_b;
  logic [7:0]    quo;
  logic [7:0]    rem;
  logic [3:0]    div_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0]    tx_wait;
  logic          tx_seen;
  logic [8:0]    rem_sh;
  logic [8:0]    rem_sub;
  logic [7:0]    calc_val;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh  = {rem, quo[7]};
  assign rem_sub = rem_sh - {1'b0, opnd_b};

  always_comb begin
    calc_val = opnd_a + opnd_b;
    case (op)
      OP_SUB:  calc_val = opnd_a - opnd_b;
      OP_MUL:  calc_val = opnd_a * opnd_b;
      OP_DIV:  calc_val = (opnd_b == 8'h00) ? ERR_BYTE : quo;
      default: calc_val = opnd_a + opnd_b;
    endcase
  end

  // NOTE: all state lives in one clocked block with non-blocking assignments, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op            <= OP_ADD;
      opnd_a        <= 8'h00;
      opnd_b        <= 8'h00;
      quo           <= 8'h00;
      rem           <= 8'h00;
      div_cnt       <= 4'd0;
      to_cnt        <= '0;
      tx_wait       <= 2'd0;
      tx_seen       <= 1'b0;
      bus.tx_data   <= 8'h00;
      bus.result    <= 8'h00;
      bus.tx_start  <= 1'b0;
      bus.div0      <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.tx_start  <= 1'b0;
      bus.div0      <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.e && bus.rx_valid) begin
            opnd_a   <= bus.rx_data;
            to_cnt   <= '0;
            bus.busy <= 1'b1;
            state    <= GOT_A;
          end
        end

        GOT_A: begin
          if (!bus.e) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (bus.rx_valid) begin
            to_cnt <= '0;
            state  <= GOT_OP;
            case (bus.rx_data)
              CH_ADD:  op <= OP_ADD;
              CH_SUB:  op <= OP_SUB;
              CH_MUL:  op <= OP_MUL;
              CH_DIV:  op <= OP_DIV;
              default: begin
                bus.frame_err <= 1'b1;
                bus.busy      <= 1'b0;
                state         <= IDLE;
              end
            endcase
          end else if (to_cnt == TO_LAST) begin
            bus.frame_err <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        GOT_OP: begin
          if (!bus.e) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (bus.rx_valid) begin
            opnd_b  <= bus.rx_data;
            rem     <= 8'h00;
            quo     <= opnd_a;
            div_cnt <= 4'd0;
            to_cnt  <= '0;
            state   <= CALC;
          end else if (to_cnt == TO_LAST) begin
            bus.frame_err <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        CALC: begin
          // Division spends 8 step cycles plus this exit cycle; other ops exit at once.
          if (op == OP_DIV && opnd_b != 8'h00 && div_cnt != 4'd8) begin
            if (rem_sub[8]) begin
              rem <= rem_sh[7:0];
              quo <= {quo[6:0], 1'b0};
            end else begin
              rem <= rem_sub[7:0];
              quo <= {quo[6:0], 1'b1};
            end
            div_cnt <= div_cnt + 4'd1;
          end else begin
            bus.result  <= calc_val;
            bus.tx_data <= calc_val;
            bus.div0    <= (op == OP_DIV) && (opnd_b == 8'h00);
            state       <= SEND;
          end
        end

        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            tx_wait      <= 2'd0;
            tx_seen      <= 1'b0;
            state        <= WAIT_TX;
          end
        end

        WAIT_TX: begin
          if (!tx_seen) begin
            if (bus.tx_busy) begin
              tx_seen <= 1'b1;
            end else if (tx_wait == 2'd3) begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_wait <= tx_wait + 2'd1;
            end
          end else if (!bus.tx_busy) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase

      if (bus.rx_valid && (state == CALC || state == SEND || state == WAIT_TX)) begin
        bus.overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_uart_responder.sv
// Randomized scoreboard bench for calc_uart_responder with a small uart-core busy model.
module tb_calc_uart_responder;

  localparam int unsigned T_CYC = 40;
  localparam logic [7:0]  ERR   = 8'hFF;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calc_uart_responder_if bus();

  calc_uart_responder #(.TIMEOUT_CYC(T_CYC), .ERR_BYTE(ERR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_edge = 0;
  int   last_ferr_cyc = -1;
  int   seen_div0 = 0, seen_ferr = 0, seen_ovr = 0;
  int   exp_div0 = 0, exp_ferr = 0, exp_ovr = 0;
  int   busy_left = 0;
  bit   hold_busy = 1'b0;
  bit   fast_core = 1'b0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the protocol's arithmetic rules in plain integer math.
  function automatic logic [7:0] ref_calc(input int a, input logic [7:0] opc, input int b);
    int r;
    case (opc)
      8'h2B:   r = (a + b) % 256;
      8'h2D:   r = (a - b + 256) % 256;
      8'h78:   r = (a * b) % 256;
      default: r = (b == 0) ? int'(ERR) : a / b;
    endcase
    return 8'(r);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // uart core model: busy for a few cycles after each start, or never (fast core), or forced.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_busy) bus.tx_busy = 1'b1;
      else if (bus.tx_start === 1'b1 && !fast_core) begin
        busy_left   = $urandom_range(2, 6);
        bus.tx_busy = 1'b1;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end else bus.tx_busy = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every transmit request and tallies pulse cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.div0 === 1'b1) seen_div0++;
      if (bus.overrun === 1'b1) seen_ovr++;
      if (bus.frame_err === 1'b1) begin
        seen_ferr++;
        last_ferr_cyc = cyc;
      end
      if (bus.tx_start === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got tx_start with tx_data=%0d, expected no transmit", bus.tx_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tx_data", 32'(bus.tx_data), 32'(e.data));
          check("result", 32'(bus.result), 32'(e.data));
          if (e.cyc >= 0) check("tx_latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    last_edge    = cyc;
    bus.rx_valid = 1'b0;
  endtask

  task automatic push_expected(input int a, input logic [7:0] opc, input int b, input bit chk_lat);
    exp_t e;
    e.data = ref_calc(a, opc, b);
    if (!chk_lat || (opc == 8'h2F && b == 0)) e.cyc = -1;
    else e.cyc = last_edge + ((opc == 8'h2F) ? 10 : 2);
    if (opc == 8'h2F && b == 0) exp_div0++;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_after_wait", 32'(bus.busy), 32'd0);
    idle(1);
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] opc, input logic [7:0] b);
    send_byte(a);
    idle($urandom_range(0, 3));
    send_byte(opc);
    idle($urandom_range(0, 3));
    send_byte(b);
    push_expected(int'(a), opc, int'(b), 1'b1);
    wait_idle();
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_div0_cycles"}, seen_div0, exp_div0);
    check({tag, "_frame_err_cycles"}, seen_ferr, exp_ferr);
    check({tag, "_overrun_cycles"}, seen_ovr, exp_ovr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({tag, "_div0"}, 32'(bus.div0), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    bus.e        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    do_frame(8'd5, 8'h2B, 8'd10);
    do_frame(8'd20, 8'h2D, 8'd30);
    do_frame(8'd15, 8'h78, 8'd20);
    do_frame(8'd50, 8'h2F, 8'd5);
    do_frame(8'd15, 8'h2F, 8'd0);
    check_pulses("directed_ops");

    // Bad operator drops the frame; the next byte starts a fresh frame.
    send_byte(8'd5);
    send_byte(8'h25);
    exp_ferr++;
    idle(1);
    check("busy_after_bad_op", 32'(bus.busy), 32'd0);
    do_frame(8'd7, 8'h2B, 8'd1);
    check_pulses("bad_op");

    // Inter-byte timeout with exact expiry cycle.
    send_byte(8'd5);
    a0 = last_edge;
    check("busy_in_got_a", 32'(bus.busy), 32'd1);
    idle(T_CYC + 3);
    exp_ferr++;
    check("timeout_cycle", last_ferr_cyc, a0 + int'(T_CYC));
    check("busy_after_timeout", 32'(bus.busy), 32'd0);
    check_pulses("timeout");

    // Operator landing on the expiry cycle is accepted.
    send_byte(8'd9);
    idle(T_CYC - 1);
    send_byte(8'h78);
    idle(2);
    send_byte(8'd3);
    push_expected(9, 8'h78, 3, 1'b1);
    wait_idle();
    check_pulses("expiry_race");

    // Enable low aborts a partial frame silently and ignores bytes in idle.
    send_byte(8'd11);
    bus.e = 1'b0;
    idle(1);
    check("busy_after_e_abort", 32'(bus.busy), 32'd0);
    send_byte(8'd12);
    idle(1);
    check("busy_e_low_idle", 32'(bus.busy), 32'd0);
    bus.e = 1'b1;
    send_byte(8'd200);
    send_byte(8'h2F);
    send_byte(8'd7);
    push_expected(200, 8'h2F, 7, 1'b1);
    bus.e = 1'b0;
    wait_idle();
    bus.e = 1'b1;
    check_pulses("enable");

    // Overrun while SEND is stalled by a busy transmitter.
    hold_busy = 1'b1;
    idle(1);
    send_byte(8'd5);
    send_byte(8'h2B);
    send_byte(8'd10);
    push_expected(5, 8'h2B, 10, 1'b0);
    idle(6);
    send_byte(8'h33);
    exp_ovr++;
    idle(3);
    check("tx_data_held_in_send", 32'(bus.tx_data), 32'd15);
    hold_busy = 1'b0;
    wait_idle();
    check_pulses("overrun");

    // Reset mid-frame, then a clean frame.
    send_byte(8'd9);
    send_byte(8'h2B);
    rst = 1'b1;
    #2;
    check_reset_outputs("mid_reset");
    idle(1);
    rst = 1'b0;
    idle(1);
    do_frame(8'd30, 8'h2D, 8'd20);

    // Randomized frames, with and without a responsive transmitter.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb, ro;
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      case ($urandom_range(0, 3))
        0:       ro = 8'h2B;
        1:       ro = 8'h2D;
        2:       ro = 8'h78;
        default: ro = 8'h2F;
      endcase
      fast_core = ($urandom_range(0, 3) == 0);
      do_frame(ra, ro, rb);
    end
    fast_core = 1'b0;
    idle(4);
    check_pulses("random");
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
